// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: IF/ID fields in, ID/EX register and interlock out.
// Latency: n/a (wiring only).
// Backpressure: ex_stall freezes the stage; load_use_stall holds IF/ID and PC.
// Ports: if_id_* decode fields, ex_stall, flush (master -> stage);
//        id_ex_* registered fields, load_use_stall, bubble_count (stage -> master).
interface id_ex_stage_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_ADDR_BITS = 5,
  parameter int ALU_OP_BITS   = 4,
  parameter int PERF_BITS     = 16
);
  logic                     if_id_valid;
  logic [REG_ADDR_BITS-1:0] if_id_rs;
  logic [REG_ADDR_BITS-1:0] if_id_rt;
  logic [REG_ADDR_BITS-1:0] if_id_rd;
  logic                     if_id_uses_rs;
  logic                     if_id_uses_rt;
  logic                     if_id_reg_write;
  logic                     if_id_mem_read;
  logic                     if_id_mem_write;
  logic [ALU_OP_BITS-1:0]   if_id_alu_op;
  logic [DATA_WIDTH-1:0]    if_id_data_a;
  logic [DATA_WIDTH-1:0]    if_id_data_b;
  logic [DATA_WIDTH-1:0]    if_id_imm;
  logic [DATA_WIDTH-1:0]    if_id_pc;
  logic                     ex_stall;
  logic                     flush;

  logic                     id_ex_valid;
  logic [REG_ADDR_BITS-1:0] id_ex_rs;
  logic [REG_ADDR_BITS-1:0] id_ex_rt;
  logic [REG_ADDR_BITS-1:0] id_ex_rd;
  logic                     id_ex_reg_write;
  logic                     id_ex_mem_read;
  logic                     id_ex_mem_write;
  logic [ALU_OP_BITS-1:0]   id_ex_alu_op;
  logic [DATA_WIDTH-1:0]    id_ex_data_a;
  logic [DATA_WIDTH-1:0]    id_ex_data_b;
  logic [DATA_WIDTH-1:0]    id_ex_imm;
  logic [DATA_WIDTH-1:0]    id_ex_pc;
  logic                     load_use_stall;
  logic [PERF_BITS-1:0]     bubble_count;

  modport master (
    output if_id_valid, if_id_rs, if_id_rt, if_id_rd, if_id_uses_rs, if_id_uses_rt,
           if_id_reg_write, if_id_mem_read, if_id_mem_write, if_id_alu_op,
           if_id_data_a, if_id_data_b, if_id_imm, if_id_pc, ex_stall, flush,
    input  id_ex_valid, id_ex_rs, id_ex_rt, id_ex_rd, id_ex_reg_write, id_ex_mem_read,
           id_ex_mem_write, id_ex_alu_op, id_ex_data_a, id_ex_data_b, id_ex_imm,
           id_ex_pc, load_use_stall, bubble_count
  );

  modport slave (
    input  if_id_valid, if_id_rs, if_id_rt, if_id_rd, if_id_uses_rs, if_id_uses_rt,
           if_id_reg_write, if_id_mem_read, if_id_mem_write, if_id_alu_op,
           if_id_data_a, if_id_data_b, if_id_imm, if_id_pc, ex_stall, flush,
    output id_ex_valid, id_ex_rs, id_ex_rt, id_ex_rd, id_ex_reg_write, id_ex_mem_read,
           id_ex_mem_write, id_ex_alu_op, id_ex_data_a, id_ex_data_b, id_ex_imm,
           id_ex_pc, load_use_stall, bubble_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use interlock and saturating bubble counter.
// Latency: 1 cycle decode capture to id_ex outputs; load_use_stall is combinational.
// Backpressure: ex_stall freezes every register; a load-use hazard inserts one bubble.
// Ports: clk, reset_n (async active-low); bus (slave modport of id_ex_stage_if).
module id_ex_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_ADDR_BITS = 5,
  parameter int ALU_OP_BITS   = 4,
  parameter int PERF_BITS     = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  id_ex_stage_if.slave  bus
);

  typedef struct packed {
    logic                     valid;
    logic [REG_ADDR_BITS-1:0] rs;
    logic [REG_ADDR_BITS-1:0] rt;
    logic [REG_ADDR_BITS-1:0] rd;
    logic                     reg_write;
    logic                     mem_read;
    logic                     mem_write;
    logic [ALU_OP_BITS-1:0]   alu_op;
    logic [DATA_WIDTH-1:0]    data_a;
    logic [DATA_WIDTH-1:0]    data_b;
    logic [DATA_WIDTH-1:0]    imm;
    logic [DATA_WIDTH-1:0]    pc;
  } stage_t;

  stage_t               stage_q;
  stage_t               capture;
  logic [PERF_BITS-1:0] bubble_q;
  logic                 hz;

  always_comb begin
    capture           = '0;
    capture.valid     = 1'b1;
    capture.rs        = bus.if_id_rs;
    capture.rt        = bus.if_id_rt;
    capture.rd        = bus.if_id_rd;
    capture.reg_write = bus.if_id_reg_write;
    capture.mem_read  = bus.if_id_mem_read;
    capture.mem_write = bus.if_id_mem_write;
    capture.alu_op    = bus.if_id_alu_op;
    capture.data_a    = bus.if_id_data_a;
    capture.data_b    = bus.if_id_data_b;
    capture.imm       = bus.if_id_imm;
    capture.pc        = bus.if_id_pc;
  end

  // A load in EX whose destination the decode instruction actually reads cannot be
  // forwarded in time. r0 is hard-wired zero, so a load to r0 is never a hazard.
  // Once the bubble is in, mem_read is 0 and the hazard drops, giving a 1-cycle stall.
  assign hz = stage_q.valid & stage_q.mem_read & (stage_q.rd != '0) & bus.if_id_valid &
              ((bus.if_id_uses_rs & (bus.if_id_rs == stage_q.rd)) |
               (bus.if_id_uses_rt & (bus.if_id_rt == stage_q.rd)));

  // A flush kills the decode instruction anyway, and a frozen stage cannot take a
  // bubble, so neither case needs IF/ID held.
  assign bus.load_use_stall = hz & ~bus.flush & ~bus.ex_stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q  <= '0;
      bubble_q <= '0;
    end else if (!bus.ex_stall) begin
      if (bus.flush || hz) begin
        // Flush and hazard in the same cycle still insert only one bubble.
        stage_q <= '0;
        if (bubble_q != '1) bubble_q <= bubble_q + 1'b1;
      end else if (!bus.if_id_valid) begin
        stage_q <= '0;
      end else begin
        stage_q <= capture;
      end
    end
  end

  assign bus.id_ex_valid     = stage_q.valid;
  assign bus.id_ex_rs        = stage_q.rs;
  assign bus.id_ex_rt        = stage_q.rt;
  assign bus.id_ex_rd        = stage_q.rd;
  assign bus.id_ex_reg_write = stage_q.reg_write;
  assign bus.id_ex_mem_read  = stage_q.mem_read;
  assign bus.id_ex_mem_write = stage_q.mem_write;
  assign bus.id_ex_alu_op    = stage_q.alu_op;
  assign bus.id_ex_data_a    = stage_q.data_a;
  assign bus.id_ex_data_b    = stage_q.data_b;
  assign bus.id_ex_imm       = stage_q.imm;
  assign bus.id_ex_pc        = stage_q.pc;
  assign bus.bubble_count    = bubble_q;

endmodule
